// File: rtl/seq_mon_pkg.sv
// Shared definitions for the Y/Z sequence monitor: FSM encoding, symbol
// constants and the double-flip helper.
package seq_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2,
    S3   = 2'd3
  } state_t;

  localparam logic [1:0] SYM_00 = 2'b00;
  localparam logic [1:0] SYM_01 = 2'b01;
  localparam logic [1:0] SYM_11 = 2'b11;
  localparam logic [1:0] SYM_10 = 2'b10;

  // True when both bits differ, i.e. Hamming distance of two.
  function automatic logic is_double_flip(input logic [1:0] a, input logic [1:0] b);
    return (a ^ b) == 2'b11;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at MAX.
module sat_counter #(
  parameter int W   = 8,
  parameter int MAX = 255
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CLR,
  input  logic         INC,
  output logic [W-1:0] Q
);

  // NOTE: clocked state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of the order the blocks are evaluated.
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      Q <= '0;
    end else if (INC && (Q != W'(MAX))) begin
      Q <= Q + W'(1);
    end
  end

endmodule

// File: rtl/seq_out_monitor.sv
// Watches the {Y,Z} outputs of the upstream sequential circuit, detects the
// Gray walk 00->01->11->10, counts detections/changes and flags ILLEGAL/STUCK.
module seq_out_monitor
  import seq_mon_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int STUCK_LIM = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CLR,
  input  logic             Y,
  input  logic             Z,
  output logic             DET,
  output logic [CNT_W-1:0] DET_CNT,
  output logic [CNT_W-1:0] CHG_CNT,
  output logic             STUCK,
  output logic             ILLEGAL,
  output logic [1:0]       STATE
);

  localparam int RUN_W   = $clog2(STUCK_LIM + 1);
  localparam int CNT_MAX = (2 ** CNT_W) - 1;

  logic [1:0]       sym;
  logic [1:0]       sym_q;
  state_t           state_q;
  state_t           state_d;
  logic             chg;
  logic             done;
  logic [RUN_W-1:0] run_q;

  assign sym   = {Y, Z};
  assign chg   = EN && (sym != sym_q);
  assign STATE = state_q;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    if (chg) begin
      if (sym == SYM_00) begin
        state_d = S1;
      end else begin
        case (state_q)
          S1:      state_d = (sym == SYM_01) ? S2 : IDLE;
          S2:      state_d = (sym == SYM_11) ? S3 : IDLE;
          S3: begin
            state_d = IDLE;
            done    = (sym == SYM_10);
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // S1 after reset because the upstream block also resets to Y=Z=0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sym_q   <= SYM_00;
      state_q <= S1;
      DET     <= 1'b0;
      STUCK   <= 1'b0;
      ILLEGAL <= 1'b0;
    end else begin
      DET <= done;
      if (EN) begin
        sym_q   <= sym;
        state_q <= state_d;
      end
      if (CLR) begin
        STUCK   <= 1'b0;
        ILLEGAL <= 1'b0;
      end else if (EN) begin
        // Mirrors run==STUCK_LIM after this edge, so STUCK lines up with run.
        STUCK <= !chg && (run_q >= RUN_W'(STUCK_LIM - 1));
        if (is_double_flip(sym_q, sym)) begin
          ILLEGAL <= 1'b1;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W), .MAX(CNT_MAX)) u_det_cnt (
    .CLK (CLK),
    .RST (RST),
    .CLR (CLR),
    .INC (done),
    .Q   (DET_CNT)
  );

  sat_counter #(.W(CNT_W), .MAX(CNT_MAX)) u_chg_cnt (
    .CLK (CLK),
    .RST (RST),
    .CLR (CLR),
    .INC (chg),
    .Q   (CHG_CNT)
  );

  // A symbol change restarts the run, so it shares the clear input.
  sat_counter #(.W(RUN_W), .MAX(STUCK_LIM)) u_run (
    .CLK (CLK),
    .RST (RST),
    .CLR (CLR || chg),
    .INC (EN && !chg),
    .Q   (run_q)
  );

endmodule

// File: tb/tb_seq_out_monitor.sv
// Scoreboard bench for seq_out_monitor: directed scenarios plus random Y/Z
// traffic, checked against a change-history reference model.
module tb_seq_out_monitor;

  localparam int CNT_W     = 4;
  localparam int STUCK_LIM = 16;
  localparam int CNT_MAX   = (2 ** CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             EN  = 1'b0;
  logic             CLR = 1'b0;
  logic             Y   = 1'b0;
  logic             Z   = 1'b0;
  logic             DET;
  logic [CNT_W-1:0] DET_CNT;
  logic [CNT_W-1:0] CHG_CNT;
  logic             STUCK;
  logic             ILLEGAL;
  logic [1:0]       STATE;

  seq_out_monitor #(.CNT_W(CNT_W), .STUCK_LIM(STUCK_LIM)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .EN      (EN),
    .CLR     (CLR),
    .Y       (Y),
    .Z       (Z),
    .DET     (DET),
    .DET_CNT (DET_CNT),
    .CHG_CNT (CHG_CNT),
    .STUCK   (STUCK),
    .ILLEGAL (ILLEGAL),
    .STATE   (STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int det;
    int det_cnt;
    int chg_cnt;
    int stuck;
    int illegal;
    int state;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: history of the last few distinct symbols seen.
  logic [1:0] hist[$];
  logic [1:0] m_symq;
  int         m_det_cnt, m_chg_cnt, m_run;
  bit         m_ill;
  logic [1:0] cur_sym = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  function automatic int tail_is(input int k, input int a, input int b, input int c, input int d);
    int n = hist.size();
    int want[4] = '{a, b, c, d};
    if (n < k) return 0;
    for (int i = 0; i < k; i++)
      if (int'(hist[n-k+i]) != want[4-k+i]) return 0;
    return 1;
  endfunction

  function automatic int model_state();
    if (tail_is(3, 0, 0, 1, 3)) return 3;
    if (tail_is(2, 0, 0, 0, 1)) return 2;
    if (tail_is(1, 0, 0, 0, 0)) return 1;
    return 0;
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic c, input logic [1:0] s);
    exp_t x;
    int   det = 0;
    if (r) begin
      hist.delete();
      hist.push_back(2'b00);
      m_symq = 2'b00; m_det_cnt = 0; m_chg_cnt = 0; m_run = 0; m_ill = 0;
    end else begin
      if (e) begin
        if (s != m_symq) begin
          hist.push_back(s);
          while (hist.size() > 4) void'(hist.pop_front());
          det       = tail_is(4, 0, 1, 3, 2);
          m_chg_cnt = (m_chg_cnt < CNT_MAX) ? m_chg_cnt + 1 : CNT_MAX;
          m_run     = 0;
        end else begin
          m_run = (m_run < STUCK_LIM) ? m_run + 1 : STUCK_LIM;
        end
        if ((s ^ m_symq) == 2'b11) m_ill = 1;
        if (det != 0) m_det_cnt = (m_det_cnt < CNT_MAX) ? m_det_cnt + 1 : CNT_MAX;
        m_symq = s;
      end
      if (c) begin
        m_det_cnt = 0; m_chg_cnt = 0; m_run = 0; m_ill = 0;
      end
    end
    x.det     = det;
    x.det_cnt = m_det_cnt;
    x.chg_cnt = m_chg_cnt;
    x.stuck   = (m_run == STUCK_LIM) ? 1 : 0;
    x.illegal = m_ill ? 1 : 0;
    x.state   = model_state();
    exp_q.push_back(x);
  endtask

  task automatic step(input logic r, input logic e, input logic c, input logic [1:0] s);
    @(negedge CLK);
    RST = r; EN = e; CLR = c; {Y, Z} = s;
    cur_sym = s;
    @(posedge CLK);
    model_edge(r, e, c, s);
  endtask

  task automatic walk(input logic c_last);
    step(0, 1, 0, 2'b00);
    step(0, 1, 0, 2'b01);
    step(0, 1, 0, 2'b11);
    step(0, 1, c_last, 2'b10);
  endtask

  // Monitor: one expected record per clock edge, compared away from the edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("det",     32'(DET),     x.det);
        check("det_cnt", 32'(DET_CNT), x.det_cnt);
        check("chg_cnt", 32'(CHG_CNT), x.chg_cnt);
        check("stuck",   32'(STUCK),   x.stuck);
        check("illegal", 32'(ILLEGAL), x.illegal);
        check("state",   32'(STATE),   x.state);
      end
    end
  end

  initial begin
    logic [1:0] s;
    logic       r, e, c;
    int         pick;

    // Reset then one clean walk, starting from the reset symbol 00.
    step(1, 0, 0, 2'b00);
    step(0, 1, 0, 2'b01);
    step(0, 1, 0, 2'b11);
    step(0, 1, 0, 2'b10);
    step(0, 1, 0, 2'b10);

    // Repeats hold S2; 00->11 is a double flip; CLR drops ILLEGAL.
    step(0, 1, 0, 2'b00);
    step(0, 1, 0, 2'b01);
    step(0, 1, 0, 2'b01);
    step(0, 1, 0, 2'b01);
    step(0, 1, 0, 2'b00);
    step(0, 1, 0, 2'b11);
    step(0, 1, 0, 2'b11);
    step(0, 1, 1, 2'b11);
    step(0, 1, 0, 2'b11);

    // Hold 01 past the stuck limit, then change.
    for (int i = 0; i < 20; i++) step(0, 1, 0, 2'b01);
    step(0, 1, 0, 2'b11);
    step(0, 1, 0, 2'b11);

    // Enough walks to saturate DET_CNT.
    for (int i = 0; i < CNT_MAX + 3; i++) walk(1'b0);

    // EN low while in S3, then complete.
    step(0, 1, 0, 2'b00);
    step(0, 1, 0, 2'b01);
    step(0, 1, 0, 2'b11);
    step(0, 0, 0, 2'b00);
    step(0, 0, 0, 2'b10);
    step(0, 0, 0, 2'b01);
    step(0, 1, 0, 2'b10);
    step(0, 1, 0, 2'b10);

    // Reset from S3 with counters nonzero; then CLR on the completing edge.
    walk(1'b0);
    step(0, 1, 0, 2'b00);
    step(0, 1, 0, 2'b01);
    step(0, 1, 0, 2'b11);
    step(1, 1, 0, 2'b10);
    step(0, 1, 0, 2'b00);
    walk(1'b1);
    step(0, 1, 0, 2'b10);

    // Random traffic biased toward the Gray walk.
    for (int i = 0; i < 3000; i++) begin
      pick = int'($urandom_range(0, 99));
      if (pick < 60)      s = {cur_sym[0], ~cur_sym[1]};
      else if (pick < 75) s = cur_sym;
      else                s = 2'($urandom_range(0, 3));
      if (($urandom_range(0, 199) == 0)) begin
        for (int k = 0; k < STUCK_LIM + 2; k++) step(0, 1, 0, cur_sym);
      end
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 49) == 0);
      step(r, e, c, s);
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
